// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3 / double dabble), one input
//   bit per clock. Feeds the 7-segment digit decoders: each bcd nibble drives
//   one decoder. A start/busy/done handshake converts the value once per request.
//
//   Optional build macro: SIGNED_EN
//     defined   : bin is two's complement; its magnitude is converted and the
//                 sign appears on neg, updated together with bcd.
//     undefined : bin is unsigned and neg is tied to 0.
//
// Parameters
//   WIDTH   binary input width (4..32)
//   DIGITS  BCD digits produced (10^DIGITS must exceed 2^WIDTH)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   conversion request, accepted whenever no conversion is running
//   bin    in   value to convert, captured on the accepting edge
//   busy   out  high while a conversion is in progress
//   done   out  one-cycle pulse when bcd/neg carry a new result
//   bcd    out  packed digits, bcd[4k+3:4k] is the 10^k digit
//   neg    out  sign of the result
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  neg
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]                 state;
   logic [CW-1:0]              count;
   logic [WIDTH-1:0]           shreg;
   logic [4*DIGITS-1:0]        digits;
   logic [4*DIGITS-1:0]        digits_adj;
   logic [4*DIGITS+WIDTH-1:0]  shifted;
   logic [4*DIGITS-1:0]        digits_nxt;
   logic [WIDTH-1:0]           shreg_nxt;
   logic [WIDTH-1:0]           magnitude;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   assign busy = (state == S_SHIFT);
   assign done = (state == S_DONE);

   // One double-dabble step: correct every digit that would overflow past 9
   // after doubling, then shift the whole {digits, shreg} chain left by one.
   always_comb begin
      digits_adj = digits;
      for (int k = 0; k < DIGITS; k++) begin
         digits_adj[4*k +: 4] = add3(digits[4*k +: 4]);
      end
      shifted    = {digits_adj, shreg} << 1;
      digits_nxt = shifted[4*DIGITS+WIDTH-1:WIDTH];
      shreg_nxt  = shifted[WIDTH-1:0];
   end

`ifdef SIGNED_EN
   logic sign_cap;

   // Negation in WIDTH bits: the most negative value maps onto its own bit
   // pattern, which read as unsigned is exactly the required magnitude.
   assign magnitude = bin[WIDTH-1] ? (~bin + 1'b1) : bin;
`else
   assign magnitude = bin;
   assign neg       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         count  <= '0;
         shreg  <= '0;
         digits <= '0;
         bcd    <= '0;
`ifdef SIGNED_EN
         sign_cap <= 1'b0;
         neg      <= 1'b0;
`endif
      end else begin
         case (state)
            // DONE accepts a new request exactly like IDLE, so a held start
            // yields back-to-back conversions.
            S_IDLE, S_DONE: begin
               if (start) begin
                  shreg  <= magnitude;
                  digits <= '0;
                  count  <= CW'(WIDTH - 1);
                  state  <= S_SHIFT;
`ifdef SIGNED_EN
                  sign_cap <= bin[WIDTH-1];
`endif
               end else begin
                  state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               shreg  <= shreg_nxt;
               digits <= digits_nxt;
               count  <= count - 1'b1;
               // bcd is only written with the finished result, so the
               // decoders never see partial sums.
               if (count == '0) begin
                  bcd   <= digits_nxt;
                  state <= S_DONE;
`ifdef SIGNED_EN
                  neg   <= sign_cap;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
   localparam int WIDTH  = 16;
   localparam int DIGITS = 5;

   logic                clk   = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [WIDTH-1:0]    bin   = '0;
   logic                busy;
   logic                done;
   logic [4*DIGITS-1:0] bcd;
   logic                neg;

   bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .neg   (neg)
   );

   always #5 clk = ~clk;

   int  n_cmp    = 0;
   int  n_fail   = 0;
   int  cyc      = 0;
   int  acc_cnt  = 0;
   int  done_cnt = 0;
   bit  armed    = 1'b0;
   bit  rst_last = 1'b1;
   logic [4*DIGITS:0]   exp_q[$];
   int                  t_q[$];
   logic [4*DIGITS-1:0] prev_bcd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: decimal digits by repeated division of the magnitude.
   function automatic logic [4*DIGITS:0] model(input logic [WIDTH-1:0] b);
      longint              m;
      logic                n;
      logic [4*DIGITS-1:0] r;
      m = longint'(b);
      n = 1'b0;
`ifdef SIGNED_EN
      if (b[WIDTH-1]) begin
         m = (longint'(1) << WIDTH) - m;
         n = 1'b1;
      end
`endif
      r = '0;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return {n, r};
   endfunction

   // Request tracker: a request is taken on any edge where start is high,
   // no conversion is running and reset is low.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         exp_q.delete();
         t_q.delete();
      end else if (start && !busy) begin
         exp_q.push_back(model(bin));
         t_q.push_back(cyc);
         acc_cnt++;
      end
      rst_last = reset;
   end

   // Output monitor
   always @(negedge clk) begin
      if (armed) begin
         logic [4*DIGITS:0] e;
         int t;
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL done_without_request: done=1 with no conversion pending (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               t = t_q.pop_front();
               chk("bcd", bcd, e[4*DIGITS-1:0]);
               chk("neg", neg, e[4*DIGITS]);
               // done is seen in the cycle after the WIDTH-th edge that follows acceptance
               chk("latency", cyc - t, WIDTH);
            end
         end else if (!rst_last) begin
            chk("bcd_hold", bcd, prev_bcd);
         end
         chk("busy", busy, (exp_q.size() > 0) && !done);
         prev_bcd = bcd;
      end
   end

   task automatic wait_accept();
      int a0 = acc_cnt;
      int n  = 0;
      while (acc_cnt == a0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (acc_cnt == a0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: start not accepted within %0d cycles", n);
      end
   endtask

   task automatic wait_idle(input int budget, input bit noise);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         start = (noise && busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
         n++;
      end
      start = 1'b0;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: %0d results pending after %0d cycles", exp_q.size(), n);
      end
   endtask

   task automatic convert(input logic [WIDTH-1:0] v, input bit noise);
      bin   = v;
      start = 1'b1;
      wait_accept();
      start = 1'b0;
      bin   = WIDTH'($urandom);
      wait_idle(100, noise);
   endtask

   initial begin
      int d0;
      logic [WIDTH-1:0] edge_vals[6];
      edge_vals = '{16'h8000, 16'h7FFF, 16'h0001, 16'h0009, 16'h000A, 16'hFFFE};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_bcd", bcd, 0);
      chk("reset_neg", neg, 0);
      prev_bcd = bcd;
      reset = 1'b0;
      armed = 1'b1;

      convert(16'd0, 1'b0);
      convert(16'd1234, 1'b0);
      convert(16'd65535, 1'b0);

      // start held high: three back-to-back conversions in 51 edges
      @(negedge clk);
      #1;
      d0    = done_cnt;
      bin   = 16'd9999;
      start = 1'b1;
      repeat (51) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(100, 1'b0);
      chk("held_done_count", done_cnt - d0, 3);

      // reset 8 cycles into a conversion
      @(negedge clk);
      #1;
      bin   = 16'd500;
      start = 1'b1;
      wait_accept();
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_bcd", bcd, 0);
      chk("midrst_neg", neg, 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      convert(16'd500, 1'b0);

      foreach (edge_vals[i]) convert(edge_vals[i], 1'b0);

      repeat (25) convert(WIDTH'($urandom), 1'b1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
